charlieplex_pwm: RTL and testbench

- Generalised charlieplexed LED matrix driver with per-pixel grayscale brightness, double-buffered frame memory and a Wishbone register interface.
- Drives pPins tri-state pins, addressing pPins*(pPins-1) LEDs, one LED lit at a time.
- Brightness comes from PWM within each pixel slot.
- Sits on the peripheral Wishbone bus next to the other display and GPIO peripherals.

---
 rtl/charlieplex_pwm.sv | 169 ++++++++++++++++
 tb/tb_charlieplex_pwm.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/charlieplex_pwm.sv
// Charlieplexed LED matrix driver: one LED lit at a time, per-pixel PWM brightness,
// double-buffered frame memory and a small byte-wide Wishbone register interface.
module charlieplex_pwm #(
  parameter int pClkHz   = 0,
  parameter int pDelayHz = 100000,
  parameter int pPins    = 7,
  parameter int pBright  = 4,
  localparam int NPix  = pPins * (pPins - 1),
  localparam int pAdrW = $clog2(NPix) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_c_stb,
  input  logic             wb_c_we,
  input  logic [pAdrW-1:0] wb_c_adr,
  input  logic [7:0]       wb_c_dat,
  output logic             wb_p_ack,
  output logic [7:0]       wb_p_dat,
  output logic [pPins-1:0] charlieplex_o,
  output logic [pPins-1:0] charlieplex_oe
);
  // A degenerate clock/tick ratio (including the pClkHz=0 default) falls back to a divide of 2.
  localparam int DivReq = (pDelayHz > 0) ? (pClkHz / pDelayHz) : 0;
  localparam int Div    = (DivReq < 2) ? 2 : DivReq;
  localparam int DW     = $clog2(Div);
  localparam int CW     = $clog2(pPins);
  localparam int PW     = pAdrW - 1;
  localparam logic [pPins-1:0] PinOne = {{(pPins-1){1'b0}}, 1'b1};

  logic [DW-1:0]      div_cnt;
  logic [CW-1:0]      scan_c;
  logic [CW-1:0]      scan_r;
  logic [pBright-1:0] scan_t;
  logic               front;
  logic               enable;
  logic               swap_pending;
  logic [5:0]         frame_cnt;
  logic [pBright-1:0] bank [2][NPix];

  logic               tick_stb;
  logic               last_t;
  logic               last_r;
  logic               last_c;
  logic               frame_end;
  logic [PW-1:0]      scan_p;
  logic [CW-1:0]      row_pin;
  logic [pBright-1:0] level;
  logic               lit;
  logic [pPins-1:0]   row_mask;
  logic [pPins-1:0]   col_mask;
  logic               access;
  logic               wr;
  logic               is_reg;
  logic [PW-1:0]      pix_idx;
  logic               pix_ok;
  logic               swap_req;
  logic [7:0]         rd_data;
  logic               unused_dat;

  assign unused_dat = ^wb_c_dat;

  // Scan decode: current pixel, its row pin and whether it is lit in this tick.
  always_comb begin
    tick_stb  = (div_cnt == '0);
    last_t    = (scan_t == '1);
    last_r    = (scan_r == CW'(pPins - 2));
    last_c    = (scan_c == CW'(pPins - 1));
    frame_end = tick_stb & last_t & last_r & last_c;
    scan_p    = PW'(int'(scan_c) * (pPins - 1) + int'(scan_r));
    row_pin   = (scan_r < scan_c) ? scan_r : scan_r + CW'(1);
    level     = bank[front][scan_p];
    lit       = enable & (scan_t != '0) & (scan_t <= level);
    row_mask  = PinOne << row_pin;
    col_mask  = PinOne << scan_c;
  end

  // Bus decode and read mux; pixel accesses only ever see the back bank.
  always_comb begin
    access   = wb_c_stb & ~wb_p_ack;
    wr       = access & wb_c_we;
    is_reg   = wb_c_adr[pAdrW-1];
    pix_idx  = wb_c_adr[PW-1:0];
    pix_ok   = (int'(pix_idx) < NPix);
    swap_req = wr & is_reg & ~wb_c_adr[0] & wb_c_dat[1];
    rd_data  = 8'h00;
    if (!is_reg) begin
      if (pix_ok) begin
        rd_data[pBright-1:0] = bank[~front][pix_idx];
      end else begin
        rd_data = 8'h00;
      end
    end else if (!wb_c_adr[0]) begin
      rd_data = {7'h00, enable};
    end else begin
      rd_data = {frame_cnt, enable, swap_pending};
    end
  end

  // Back-bank pixel writes; frame memory has no reset.
  always_ff @(posedge clk) begin
    if (wr && !is_reg && pix_ok) begin
      bank[~front][pix_idx] <= wb_c_dat[pBright-1:0];
    end
  end

  // Tick divider and tick -> row -> column scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      scan_t  <= '0;
      scan_r  <= '0;
      scan_c  <= '0;
    end else begin
      div_cnt <= (div_cnt == DW'(Div - 1)) ? '0 : div_cnt + DW'(1);
      if (tick_stb) begin
        scan_t <= scan_t + pBright'(1);
        if (last_t) begin
          if (last_r) begin
            scan_r <= '0;
            scan_c <= last_c ? '0 : scan_c + CW'(1);
          end else begin
            scan_r <= scan_r + CW'(1);
          end
        end
      end
    end
  end

  // Control state; a new swap request beats the clear at frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front        <= 1'b0;
      enable       <= 1'b0;
      swap_pending <= 1'b0;
      frame_cnt    <= 6'd0;
    end else begin
      if (frame_end) begin
        frame_cnt <= frame_cnt + 6'd1;
        if (swap_pending) begin
          front <= ~front;
        end
      end
      if (swap_req) begin
        swap_pending <= 1'b1;
      end else if (frame_end) begin
        swap_pending <= 1'b0;
      end
      if (wr && is_reg && !wb_c_adr[0]) begin
        enable <= wb_c_dat[0];
      end
    end
  end

  // Registered pin drive and bus response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      charlieplex_o  <= '0;
      charlieplex_oe <= '0;
      wb_p_ack       <= 1'b0;
      wb_p_dat       <= 8'h00;
    end else begin
      charlieplex_o  <= lit ? row_mask : '0;
      charlieplex_oe <= lit ? (row_mask | col_mask) : '0;
      wb_p_ack       <= access;
      wb_p_dat       <= access ? rd_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_charlieplex_pwm.sv
// Bench for charlieplex_pwm (3 pins, 2-bit brightness, tick every 2 clocks): directed
// scenarios plus random bus traffic, all checked every cycle against a frame-level model.
module tb_charlieplex_pwm;
  localparam logic [3:0] ADR_CTRL = 4'h8;
  localparam logic [3:0] ADR_STAT = 4'h9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wb_c_stb = 1'b0;
  logic       wb_c_we = 1'b0;
  logic [3:0] wb_c_adr = 4'h0;
  logic [7:0] wb_c_dat = 8'h00;
  logic       wb_p_ack;
  logic [7:0] wb_p_dat;
  logic [2:0] charlieplex_o;
  logic [2:0] charlieplex_oe;

  int vectors = 0;
  int miscompares = 0;

  // Model: the scan position is simply the count of ticks seen since reset.
  int         mk, mt, mfc;
  bit         men, mpend, msel, mack;
  logic [7:0] mdat;
  logic [2:0] mo, moe;
  logic [1:0] mbank [2][6];

  charlieplex_pwm #(
    .pClkHz(200000), .pDelayHz(100000), .pPins(3), .pBright(2)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_c_stb(wb_c_stb), .wb_c_we(wb_c_we), .wb_c_adr(wb_c_adr), .wb_c_dat(wb_c_dat),
    .wb_p_ack(wb_p_ack), .wb_p_dat(wb_p_dat),
    .charlieplex_o(charlieplex_o), .charlieplex_oe(charlieplex_oe)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mk = 0; mt = 0; mfc = 0;
    men = 1'b0; mpend = 1'b0; msel = 1'b0; mack = 1'b0;
    mdat = 8'h00; mo = 3'b000; moe = 3'b000;
  endtask

  // Predict the effect of the coming clock edge from the inputs now applied.
  task automatic model_step();
    int pos, p, t, c, r, row, idx;
    bit lit, acc, swreq;
    logic [7:0] rdv;
    pos = mt % 24;
    p = pos / 4; t = pos % 4; c = p / 2; r = p % 2;
    row = (r < c) ? r : r + 1;
    lit = men && (t != 0) && (t <= int'(mbank[msel][p]));
    mo  = lit ? 3'(1 << row) : 3'b000;
    moe = lit ? 3'((1 << row) | (1 << c)) : 3'b000;
    acc = wb_c_stb && !mack;
    idx = int'(wb_c_adr[2:0]);
    rdv = 8'h00;
    if (!wb_c_adr[3]) begin
      if (idx < 6) rdv = {6'd0, mbank[!msel][idx]};
    end else if (!wb_c_adr[0]) begin
      rdv = {7'd0, men};
    end else begin
      rdv = {6'(mfc), men, mpend};
    end
    mdat = acc ? rdv : 8'h00;
    mack = acc;
    swreq = 1'b0;
    if (acc && wb_c_we) begin
      if (!wb_c_adr[3]) begin
        if (idx < 6) mbank[!msel][idx] = wb_c_dat[1:0];
      end else if (!wb_c_adr[0]) begin
        men = wb_c_dat[0];
        swreq = wb_c_dat[1];
      end
    end
    if (mk % 2 == 0) begin
      mt++;
      if (mt % 24 == 0) begin
        mfc = (mfc + 1) % 64;
        if (mpend) msel = !msel;
        mpend = 1'b0;
      end
    end
    if (swreq) mpend = 1'b1;
    mk++;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_eq("pins", {26'd0, charlieplex_o, charlieplex_oe}, {26'd0, mo, moe});
    check_eq("bus", {23'd0, wb_p_ack, wb_p_dat}, {23'd0, mack, mdat});
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    wb_c_stb = 1'b1; wb_c_we = 1'b1; wb_c_adr = a; wb_c_dat = d;
    cycle();
    wb_c_stb = 1'b0; wb_c_we = 1'b0;
    cycle();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    wb_c_stb = 1'b1; wb_c_we = 1'b0; wb_c_adr = a;
    cycle();
    d = wb_p_dat;
    wb_c_stb = 1'b0;
    cycle();
  endtask

  task automatic wait_swap(input string tag);
    logic [7:0] s;
    s = 8'h01;
    for (int i = 0; i < 40 && s[0]; i++) bus_read(ADR_STAT, s);
    check_eq(tag, {31'd0, s[0]}, 32'd0);
  endtask

  task automatic wait_phase(input int ph);
    while (mk % 48 != ph) cycle();
  endtask

  task automatic count_pat(input logic [5:0] pat, input int n, output int hits, output int any);
    hits = 0; any = 0;
    repeat (n) begin
      cycle();
      if ({charlieplex_o, charlieplex_oe} == pat) hits++;
      if (charlieplex_oe != 3'b000) any++;
    end
  endtask

  initial begin
    logic [7:0] s;
    int hits, any, acks, b2b, rv, op;
    bit found, prev;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 6; i++) mbank[b][i] = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold", {26'd0, charlieplex_o, charlieplex_oe}, 32'd0);
    rst = 1'b1;
    bus_read(ADR_STAT, s);
    check_eq("stat_after_rst", {24'd0, s}, 32'h00);

    // Clear both banks.
    for (int i = 0; i < 6; i++) bus_write(4'(i), 8'h00);
    bus_write(ADR_CTRL, 8'h02);
    wait_swap("clr_swap");
    for (int i = 0; i < 6; i++) bus_write(4'(i), 8'h00);

    // Mapping: pixel 3 (c=1, r=1) drives row pin 2.
    bus_write(4'h3, 8'h03);
    bus_write(ADR_CTRL, 8'h03);
    wait_swap("map_swap");
    count_pat(6'b100_110, 48, hits, any);
    check_eq("map_hits", hits, 32'd6);
    check_eq("map_any", any, 32'd6);

    // Asynchronous reset in the middle of a lit slot.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      found = (charlieplex_oe != 3'b000);
    end
    check_eq("lit_before_rst", {31'd0, found}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_async", {26'd0, charlieplex_o, charlieplex_oe}, 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus_read(ADR_STAT, s);
    check_eq("stat_after_rst2", {24'd0, s}, 32'h00);

    // Frame counter: 63 frames then wrap at the 64th.
    while (mk < 3068) cycle();
    bus_read(ADR_STAT, s);
    check_eq("fc_63", {24'd0, s}, 32'hFC);
    while (mk < 3080) cycle();
    bus_read(ADR_STAT, s);
    check_eq("fc_wrap", {24'd0, s}, 32'h00);

    // PWM duty per level.
    bus_write(4'h0, 8'h01);
    bus_write(4'h1, 8'h02);
    bus_write(ADR_CTRL, 8'h03);
    wait_swap("pwm_swap");
    count_pat(6'b010_011, 48, hits, any);
    check_eq("pwm_lvl1", hits, 32'd2);
    check_eq("pwm_any", any, 32'd6);
    count_pat(6'b100_101, 48, hits, any);
    check_eq("pwm_lvl2", hits, 32'd4);

    // Double buffer: back-bank writes invisible until the swap.
    bus_write(4'h3, 8'h00);
    bus_write(4'h5, 8'h03);
    count_pat(6'b010_011, 144, hits, any);
    check_eq("db_hold_hits", hits, 32'd6);
    check_eq("db_hold_any", any, 32'd18);
    wait_phase(10);
    bus_write(ADR_CTRL, 8'h03);
    bus_read(ADR_STAT, s);
    check_eq("db_pending", {31'd0, s[0]}, 32'd1);
    wait_swap("db_swap");
    count_pat(6'b010_110, 48, hits, any);
    check_eq("db_new_hits", hits, 32'd6);
    check_eq("db_new_any", any, 32'd6);

    // Bus corner cases.
    bus_write(4'h3, 8'hFF);
    bus_read(4'h3, s);
    check_eq("rd_trunc", {24'd0, s}, 32'h03);
    bus_write(4'h6, 8'h03);
    bus_read(4'h6, s);
    check_eq("rd_idx6", {24'd0, s}, 32'h00);
    bus_read(4'h7, s);
    check_eq("rd_idx7", {24'd0, s}, 32'h00);
    wb_c_stb = 1'b1; wb_c_we = 1'b0; wb_c_adr = ADR_CTRL;
    acks = 0; b2b = 0; prev = 1'b0;
    repeat (4) begin
      cycle();
      if (wb_p_ack) acks++;
      if (wb_p_ack && prev) b2b++;
      prev = wb_p_ack;
    end
    wb_c_stb = 1'b0;
    cycle();
    check_eq("held_b2b", b2b, 32'd0);
    check_eq("held_seen", {31'd0, acks > 0}, 32'd1);

    // Swap request landing exactly on the frame-end edge.
    wait_phase(10);
    bus_write(ADR_CTRL, 8'h03);
    wait_phase(46);
    bus_write(ADR_CTRL, 8'h03);
    bus_read(ADR_STAT, s);
    check_eq("coinc_stat", {30'd0, s[1:0]}, 32'd3);
    count_pat(6'b100_110, 40, hits, any);
    check_eq("coinc_swapped", hits, 32'd6);

    // Random traffic.
    repeat (250) begin
      op = $urandom_range(0, 3);
      rv = $urandom;
      case (op)
        0: bus_write({1'b0, 3'(rv)}, 8'(rv >> 8));
        1: bus_write({1'b1, 3'(rv)}, {6'd0, rv[5], (rv[7:6] != 2'd0)});
        2: bus_read(4'($urandom_range(0, 15)), s);
        default: repeat ($urandom_range(0, 4)) cycle();
      endcase
    end
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
